// File: rtl/fir_pkg.sv
// fir_pkg -- shared types and helpers for the FIR inverse block.
//   state_t   : controller state encoding
//   tap_idx_w : width of the tap down-counter for a given tap count
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // The MAC counter runs T-2 down to 0, so it needs enough bits for T-2.
  // Never narrower than one bit so T = 1 and T = 2 still elaborate.
  function automatic int tap_idx_w(input int t);
    int w;
    w = 1;
    while ((1 << w) < (t - 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/fir_inv_hist.sv
// fir_inv_hist -- history shift register of recovered samples.
//   Parameters: T (taps), NI (sample width); holds T-1 entries.
//   CLK      : clock
//   RST      : asynchronous active-high reset, clears all entries
//   shift_en : push din into entry 0, older entries move up by one
//   din      : newest recovered sample
//   dout     : parallel read, dout[i] is the sample i+1 steps old
module fir_inv_hist #(
  parameter int T  = 4,
  parameter int NI = 8,
  localparam int HN = (T > 1) ? T - 1 : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   shift_en,
  input  logic [NI-1:0]          din,
  output logic [HN-1:0][NI-1:0]  dout
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout <= '0;
    end else if (shift_en) begin
      dout[0] <= din;
      for (int i = 1; i < HN; i++) dout[i] <= dout[i-1];
    end
  end

endmodule

// File: rtl/fir_inv.sv
// fir_inv -- recovers X from Y = sum_k W[k]*X[n-k] (mod 2^NO) with W[0] = 1,
// one sample at a time: X[n] = Y[n] - sum_{k>=1} W[k]*X[n-k], one MAC per cycle.
//   Parameters: T (taps), NI (X / coefficient width), NO (Y / arithmetic width)
//   CLK, RST             : clock, asynchronous active-high reset
//   IN_VALID / IN_READY  : input handshake for Y and W
//   Y                    : filtered sample, unsigned mod 2^NO
//   W                    : coefficients, W[0] is ignored (treated as 1)
//   OUT_VALID / OUT_READY: output handshake for X and ERR
//   X                    : recovered sample
//   ERR                  : recovered value overflowed NI bits
// Build option: define FIR_INV_CHECK_EN to enable the ERR overflow check;
// without it ERR is constant 0.
module fir_inv
  import fir_pkg::*;
#(
  parameter int T  = 4,
  parameter int NI = 8,
  parameter int NO = 2 * NI
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [NO-1:0]         Y,
  input  logic [T-1:0][NI-1:0]  W,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [NI-1:0]         X,
  output logic                  ERR
);

  // state | meaning
  // IDLE  | waiting for an input sample (IN_READY once out of reset)
  // MAC   | one W[k]*history[k] accumulate per cycle, k = T-1 .. 1
  // FIN   | X = Yreg - acc registered, overflow check registered
  // OUT   | X valid, held until OUT_READY

  localparam int HN = (T > 1) ? T - 1 : 1;
  localparam int CW = tap_idx_w(T);

  state_t                 state, state_nxt;
  logic                   run;
  logic [CW-1:0]          cnt;
  logic [NO-1:0]          y_reg, acc, diff, prod;
  logic [HN-1:0][NI-1:0]  w_reg, hist;
  logic                   in_hs, out_hs;
  logic                   unused_w0;

  assign unused_w0 = ^W[0];

  // run holds IN_READY low until the first edge after reset is released.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = run;
        if (IN_VALID && run) state_nxt = (T > 1) ? MAC : FIN;
      end
      MAC: begin
        if (cnt == '0) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = OUT;
      end
      OUT: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_hs  = IN_VALID && IN_READY;
  assign out_hs = OUT_VALID && OUT_READY;

  // Coefficient and history entry i both belong to tap k = i+1.
  assign prod = NO'(w_reg[cnt]) * NO'(hist[cnt]);
  assign diff = y_reg - acc;

`ifdef FIR_INV_CHECK_EN
  logic err_q;
`else
  logic unused_diff_hi;
  assign unused_diff_hi = ^diff[NO-1:NI];
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      y_reg <= '0;
      acc   <= '0;
      w_reg <= '0;
      X     <= '0;
`ifdef FIR_INV_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      if (in_hs) begin
        y_reg <= Y;
        acc   <= '0;
        cnt   <= CW'(T - 2);
        // (i+1) % T keeps the index legal when T = 1 (MAC never runs then).
        for (int i = 0; i < HN; i++) w_reg[i] <= W[(i + 1) % T];
      end
      if (state == MAC) begin
        acc <= acc + prod;
        cnt <= cnt - 1'b1;
      end
      if (state == FIN) begin
        X <= diff[NI-1:0];
`ifdef FIR_INV_CHECK_EN
        err_q <= |diff[NO-1:NI];
`endif
      end
    end
  end

`ifdef FIR_INV_CHECK_EN
  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  generate
    if (T > 1) begin : g_hist
      fir_inv_hist #(
        .T  (T),
        .NI (NI)
      ) u_hist (
        .CLK      (CLK),
        .RST      (RST),
        .shift_en (out_hs),
        .din      (X),
        .dout     (hist)
      );
    end else begin : g_no_hist
      assign hist = '0;
    end
  endgenerate

endmodule

// File: tb/tb_fir_inv.sv
module tb_fir_inv;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              IN_VALID = 1'b0;
  logic              IN_READY;
  logic [15:0]       Y = '0;
  logic [3:0][7:0]   W = '0;
  logic              OUT_VALID;
  logic              OUT_READY = 1'b0;
  logic [7:0]        X;
  logic              ERR;

  logic [3:0][7:0]   w_v;
  int checks = 0;
  int errors = 0;

  fir_inv #(.T(4), .NI(8), .NO(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .Y         (Y),
    .W         (W),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .X         (X),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Present one sample, check latency and result, optionally stall OUT_READY.
  task automatic send(input string tag, input logic [15:0] y, input logic [7:0] ex,
                      input logic ee, input int stall);
    int n;
    n = 0;
    while (!IN_READY && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, " in_ready"}, IN_READY, 1);
    IN_VALID = 1'b1;
    Y = y;
    W = w_v;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    Y = '0;
    W = '0;
    n = 0;
    while (!OUT_VALID && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " x"}, X, ex);
    check({tag, " err"}, ERR, ee);
    for (int s = 0; s < stall; s++) begin
      IN_VALID = 1'b1;
      Y = 16'hffff;
      W = w_v;
      @(posedge CLK); #1;
      check({tag, " stall x"}, X, ex);
      check({tag, " stall err"}, ERR, ee);
      check({tag, " stall out_valid"}, OUT_VALID, 1);
      check({tag, " stall in_ready"}, IN_READY, 0);
    end
    IN_VALID = 1'b0;
    Y = '0;
    W = '0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    check({tag, " out_valid drop"}, OUT_VALID, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  xr, m1, m2, m3;
    logic [15:0] yv;
    logic        spur;
    logic        exp_ovf;

    w_v = {8'd4, 8'd3, 8'd2, 8'd1};
`ifdef FIR_INV_CHECK_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst in_ready", IN_READY, 0);
    check("rst out_valid", OUT_VALID, 0);
    check("rst x", X, 0);
    check("rst err", ERR, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("rel in_ready before edge", IN_READY, 0);
    @(posedge CLK); #1;
    check("rel in_ready after edge", IN_READY, 1);

    // history chain: 5, 7, 11, 3 (stalled), 1
    send("y5",   16'd5,      8'd5,  1'b0, 0);
    send("y17",  16'd17,     8'd7,  1'b0, 0);
    send("y28",  16'h0028,   8'd11, 1'b0, 0);
    send("y66",  16'd66,     8'd3,  1'b0, 3);   // 3+2*11+3*7+4*5
    send("y68",  16'd68,     8'd1,  1'b0, 0);   // 1+2*3+3*11+4*7

    // overflow with cleared history
    do_reset();
    send("y100", 16'h0100,   8'h00, exp_ovf, 0);

    // reset in the middle of MAC must wipe history and suppress output
    send("y5b",  16'd5,      8'd5,  1'b0, 0);
    IN_VALID = 1'b1;
    Y = 16'd50;
    W = w_v;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    Y = '0;
    W = '0;
    @(posedge CLK); #1;
    RST = 1'b1;
    #1;
    check("midrst out_valid", OUT_VALID, 0);
    check("midrst in_ready", IN_READY, 0);
    check("midrst x", X, 0);
    #1;
    RST = 1'b0;
    spur = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
      spur = spur | OUT_VALID;
    end
    check("midrst spurious out_valid", spur, 0);
    send("y9",   16'd9,      8'd9,  1'b0, 0);

    // loopback through a bench-side forward FIR
    do_reset();
    m1 = '0; m2 = '0; m3 = '0;
    for (int i = 0; i < 200; i++) begin
      xr = 8'($urandom_range(0, 255));
      yv = {8'd0, xr} + 16'd2 * {8'd0, m1} + 16'd3 * {8'd0, m2} + 16'd4 * {8'd0, m3};
      send("loop", yv, xr, 1'b0, 0);
      m3 = m2; m2 = m1; m1 = xr;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
